tx_release_sched: RTL

- Timestamp-driven release controller for the TX frame slot ring, clocked in the GMII TX domain.
- Host logic writes complete frames into the slot RAM and advances host_wr_ptr. This block parses each frame header through the RAM's second read port.
- It advances mem_wr_ptr, the pointer the sender consumes up to, one frame at a time, only once global_counter reaches the frame's 64-bit TX timestamp.
- This turns the sender's run-until-empty behaviour into scheduled, per-frame transmission.

---
 rtl/tx_release_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tx_release_sched.sv
// Timestamp-driven release controller for the TX slot ring: parses each frame
// header through the RAM's second port and advances mem_wr_ptr once it is due.
module tx_release_sched #(
  parameter logic [63:0] LATE_TOL = 64'd125,
  parameter logic [15:0] MAX_LEN  = 16'd9018
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] global_counter,
  input  logic        sched_en,
  input  logic [13:0] host_wr_ptr,
  input  logic [13:0] mem_rd_ptr,
  output logic [13:0] hdr_addr,
  output logic        hdr_rd_en,
  input  logic [15:0] hdr_q,
  output logic [13:0] mem_wr_ptr,
  output logic        sched_busy,
  output logic        fmt_err,
  output logic [15:0] late_count,
  output logic [13:0] pending_words
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_CHECK = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [13:0] next_ptr_q, next_ptr_d;
  logic [13:0] mem_wr_ptr_q, mem_wr_ptr_d;
  logic [15:0] len_q, len_d;
  logic [63:0] ts_q, ts_d;
  logic        fmt_err_q, fmt_err_d;
  logic [15:0] late_q, late_d;
  logic [13:0] pending_q;

  // Reset asserts asynchronously but is released in step with gmii_tx_clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [16:0] len_plus1;
  logic [16:0] size_w;
  logic [13:0] avail_w;
  logic [63:0] lateness_w;
  logic        release_ok;
  logic        late_hit;

  assign len_plus1  = {1'b0, len_q} + 17'd1;
  assign size_w     = (len_plus1 >> 1) + 17'd7;
  assign avail_w    = host_wr_ptr - next_ptr_q;
  assign lateness_w = global_counter - ts_q;
  assign release_ok = !sched_en || (ts_q == 64'd0) || (global_counter >= ts_q);
  // A zero timestamp means "send now", so it can never be late.
  assign late_hit   = sched_en && (ts_q != 64'd0) && (global_counter >= ts_q) &&
                      (lateness_w > LATE_TOL);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    next_ptr_d   = next_ptr_q;
    mem_wr_ptr_d = mem_wr_ptr_q;
    len_d        = len_q;
    ts_d         = ts_q;
    fmt_err_d    = fmt_err_q;
    late_d       = late_q;
    hdr_rd_en    = 1'b0;
    hdr_addr     = 14'd0;

    case (state_q)
      S_IDLE: begin
        if (next_ptr_q != host_wr_ptr) begin
          idx_d   = 3'd0;
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        // Reads issue on idx 0..4; each word lands one cycle later (idx 1..5).
        if (idx_q < 3'd5) begin
          hdr_rd_en = 1'b1;
          hdr_addr  = next_ptr_q + {11'd0, idx_q};
        end
        case (idx_q)
          3'd1: len_d        = hdr_q;
          3'd2: ts_d[63:48]  = hdr_q;
          3'd3: ts_d[47:32]  = hdr_q;
          3'd4: ts_d[31:16]  = hdr_q;
          3'd5: begin
            ts_d[15:0] = hdr_q;
            state_d    = S_CHECK;
          end
          default: ;
        endcase
        idx_d = idx_q + 3'd1;
      end

      S_CHECK: begin
        if ((len_q > MAX_LEN) || (size_w > {3'd0, avail_w})) begin
          fmt_err_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (release_ok) begin
          next_ptr_d   = next_ptr_q + size_w[13:0];
          mem_wr_ptr_d = next_ptr_q + size_w[13:0];
          if (late_hit && (late_q != 16'hFFFF)) late_d = late_q + 16'd1;
          state_d = S_IDLE;
        end
      end

      S_HALT: ;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n || !rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      next_ptr_q   <= 14'd0;
      mem_wr_ptr_q <= 14'd0;
      len_q        <= 16'd0;
      ts_q         <= 64'd0;
      fmt_err_q    <= 1'b0;
      late_q       <= 16'd0;
      pending_q    <= 14'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      next_ptr_q   <= next_ptr_d;
      mem_wr_ptr_q <= mem_wr_ptr_d;
      len_q        <= len_d;
      ts_q         <= ts_d;
      fmt_err_q    <= fmt_err_d;
      late_q       <= late_d;
      pending_q    <= mem_wr_ptr_q - mem_rd_ptr;
    end
  end

  assign mem_wr_ptr    = mem_wr_ptr_q;
  assign sched_busy    = (state_q != S_IDLE);
  assign fmt_err       = fmt_err_q;
  assign late_count    = late_q;
  assign pending_words = pending_q;

endmodule
